regfile_wb_arbiter: RTL and testbench

//  Drives the single write port (we/wn/d) of the CPU register file.
//  - Two sources share that port:
//    - pipeline write-back (ALU/load): always accepted, priority.
//    - long-latency mul/div unit (MDU): valid/ready handshake, buffered in a small FIFO.
//  - Writes are launched on posedge clk; the register file commits them on the following negedge.
//  - Reports pending-write hazards to the decode stage so it can stall.

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter.
// The pipeline write-back path always has priority on the single regfile
// write port. Mul/div results enter a small FIFO through a valid/ready
// handshake and drain whenever the pipeline leaves the port idle.
// Queue entries carry a live bit. A younger pipeline write to the same
// register clears that bit, so an older MDU result can never overwrite it.
// The decode stage is told about any register that still has a live
// write waiting in the queue.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_wn,
    input  logic [31:0]                pipe_d,
    input  logic                       mdu_valid,
    input  logic [4:0]                 mdu_wn,
    input  logic [31:0]                mdu_d,
    output logic                       mdu_ready,
    input  logic [4:0]                 rna,
    input  logic [4:0]                 rnb,
    output logic                       hazard_a,
    output logic                       hazard_b,
    output logic                       we,
    output logic [4:0]                 wn,
    output logic [31:0]                d,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] live;
    logic [4:0]       qwn [DEPTH];
    logic [31:0]      qd  [DEPTH];

    logic pipe_req;
    logic push;
    logic pop;
    logic push_live;

    // A pipeline write to r0 is treated as no request at all.
    assign pipe_req  = pipe_we && (pipe_wn != 5'd0);
    assign mdu_ready = (count < CW'(DEPTH));
    // A result for r0 completes the handshake but is never stored.
    assign push      = mdu_valid && mdu_ready && (mdu_wn != 5'd0);
    assign pop       = !pipe_req && (count != '0);
    // A simultaneous pipeline write to the same register is younger, so it wins.
    assign push_live = !(pipe_req && (pipe_wn == mdu_wn));
    assign q_count   = count;

    // Queue storage, live bits, pointers and occupancy.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            live  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qwn[i] <= 5'd0;
                qd[i]  <= 32'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_req && (qwn[i] == pipe_wn)) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + AW'(1);
            end
            if (push) begin
                live[tail] <= push_live;
                qwn[tail]  <= mdu_wn;
                qd[tail]   <= mdu_d;
                tail       <= tail + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port: pipeline first, then queue head, otherwise idle with wn/d held.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we <= 1'b0;
            wn <= 5'd0;
            d  <= 32'd0;
        end else if (pipe_req) begin
            we <= 1'b1;
            wn <= pipe_wn;
            d  <= pipe_d;
        end else if (pop) begin
            we <= live[head];
            if (live[head]) begin
                wn <= qwn[head];
                d  <= qd[head];
            end
        end else begin
            we <= 1'b0;
        end
    end

    // Flag decode reads whose register still has a live queued write.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (qwn[i] == rna) && (rna != 5'd0)) begin
                hazard_a = 1'b1;
            end
            if (live[i] && (qwn[i] == rnb) && (rnb != 5'd0)) begin
                hazard_b = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// A queue-based reference model tracks pending MDU writes and the expected
// write-port output. A small register file written from the DUT outputs
// shows what the CPU would actually commit.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        live;
        logic [4:0]  wn;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        clrn;
    logic        pipe_we;
    logic [4:0]  pipe_wn;
    logic [31:0] pipe_d;
    logic        mdu_valid;
    logic [4:0]  mdu_wn;
    logic [31:0] mdu_d;
    logic        mdu_ready;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        hazard_a;
    logic        hazard_b;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [2:0]  q_count;

    ent_t        mq[$];
    logic        expWe;
    logic [4:0]  expWn;
    logic [31:0] expD;
    logic [31:0] modelRf [32];
    logic [31:0] rf [32];
    logic        accepted;
    int          checks;
    int          fails;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clrn(clrn),
        .pipe_we(pipe_we), .pipe_wn(pipe_wn), .pipe_d(pipe_d),
        .mdu_valid(mdu_valid), .mdu_wn(mdu_wn), .mdu_d(mdu_d), .mdu_ready(mdu_ready),
        .rna(rna), .rnb(rnb), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .we(we), .wn(wn), .d(d), .q_count(q_count)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the DUT write port; it commits on the falling edge.
    always @(negedge clk) begin
        if (we) rf[wn] <= d;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic modelHazard(input logic [4:0] r);
        modelHazard = 1'b0;
        if (r != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].wn == r) modelHazard = 1'b1;
            end
        end
    endfunction

    // Model of one rising edge, written from the arbitration rules.
    task automatic modelEdge();
        logic ready;
        logic preq;
        ent_t h;
        ready    = (mq.size() < DEPTH);
        preq     = pipe_we && (pipe_wn != 5'd0);
        accepted = mdu_valid && ready;
        if (preq) begin
            expWe = 1'b1;
            expWn = pipe_wn;
            expD  = pipe_d;
        end else if (mq.size() > 0) begin
            h     = mq.pop_front();
            expWe = h.live;
            if (h.live) begin
                expWn = h.wn;
                expD  = h.d;
            end
        end else begin
            expWe = 1'b0;
        end
        if (preq) begin
            foreach (mq[i]) begin
                if (mq[i].wn == pipe_wn) mq[i].live = 1'b0;
            end
        end
        if (accepted && mdu_wn != 5'd0) begin
            mq.push_back('{live: !(preq && pipe_wn == mdu_wn), wn: mdu_wn, d: mdu_d});
        end
        if (expWe) modelRf[expWn] = expD;
    endtask

    // Drive one cycle of inputs, check combinational outputs, clock, then check registered outputs.
    task automatic applyStimulus(input logic pwe, input logic [4:0] pwn, input logic [31:0] pd,
                                 input logic mv, input logic [4:0] mwn, input logic [31:0] md,
                                 input logic [4:0] ra, input logic [4:0] rb);
        pipe_we = pwe; pipe_wn = pwn; pipe_d = pd;
        mdu_valid = mv; mdu_wn = mwn; mdu_d = md;
        rna = ra; rnb = rb;
        #1;
        checkOutput("hazard_a", {31'b0, hazard_a}, {31'b0, modelHazard(ra)});
        checkOutput("hazard_b", {31'b0, hazard_b}, {31'b0, modelHazard(rb)});
        checkOutput("mdu_ready", {31'b0, mdu_ready}, {31'b0, mq.size() < DEPTH});
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("we", {31'b0, we}, {31'b0, expWe});
        checkOutput("wn", {27'b0, wn}, {27'b0, expWn});
        checkOutput("d", d, expD);
        checkOutput("q_count", {29'b0, q_count}, mq.size());
    endtask

    task automatic idle(input int n, input logic [4:0] ra);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, ra, 0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        for (int i = 0; i < 32; i++) begin
            rf[i]      = 32'd0;
            modelRf[i] = 32'd0;
        end
        expWe = 1'b0; expWn = 5'd0; expD = 32'd0;
        clrn = 1'b0;
        pipe_we = 0; pipe_wn = 0; pipe_d = 0;
        mdu_valid = 0; mdu_wn = 0; mdu_d = 0;
        rna = 0; rnb = 0;
        #12;
        checkOutput("rst_we", {31'b0, we}, 0);
        checkOutput("rst_wn", {27'b0, wn}, 0);
        checkOutput("rst_d", d, 0);
        checkOutput("rst_q_count", {29'b0, q_count}, 0);
        checkOutput("rst_ready", {31'b0, mdu_ready}, 1);
        clrn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] reset with three queued entries");
        applyStimulus(1, 1, 32'h11, 1, 10, 32'hA0, 10, 0);
        applyStimulus(1, 1, 32'h12, 1, 11, 32'hA1, 10, 0);
        applyStimulus(1, 1, 32'h13, 1, 12, 32'hA2, 10, 0);
        checkOutput("pre_rst_q_count", {29'b0, q_count}, 3);
        checkOutput("pre_rst_hazard_a", {31'b0, hazard_a}, 1);
        pipe_we = 0; mdu_valid = 0;
        #2 clrn = 1'b0;
        #1;
        checkOutput("midrst_we", {31'b0, we}, 0);
        checkOutput("midrst_q_count", {29'b0, q_count}, 0);
        checkOutput("midrst_ready", {31'b0, mdu_ready}, 1);
        checkOutput("midrst_hazard_a", {31'b0, hazard_a}, 0);
        mq.delete();
        expWe = 1'b0; expWn = 5'd0; expD = 32'd0;
        #1 clrn = 1'b1;
        idle(2, 10);

        $display("[TB] lone MDU write");
        applyStimulus(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 5, 0);
        checkOutput("lone_q_count", {29'b0, q_count}, 1);
        checkOutput("lone_we_early", {31'b0, we}, 0);
        idle(1, 5);
        checkOutput("lone_we", {31'b0, we}, 1);
        checkOutput("lone_wn", {27'b0, wn}, 5);
        checkOutput("lone_d", d, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        checkOutput("lone_rf5", rf[5], 32'hDEAD_BEEF);
        idle(1, 0);

        $display("[TB] pipeline priority over queued r6");
        applyStimulus(1, 1, 32'h21, 1, 6, 32'h66, 6, 0);
        applyStimulus(1, 7, 32'h77, 0, 0, 0, 6, 0);
        checkOutput("prio_hz_r7", {31'b0, hazard_a}, 1);
        applyStimulus(1, 8, 32'h88, 0, 0, 0, 6, 0);
        applyStimulus(1, 9, 32'h99, 0, 0, 0, 6, 0);
        checkOutput("prio_wn_r9", {27'b0, wn}, 9);
        checkOutput("prio_hz_r9", {31'b0, hazard_a}, 1);
        idle(1, 6);
        checkOutput("prio_wn_r6", {27'b0, wn}, 6);
        checkOutput("prio_hz_after", {31'b0, hazard_a}, 0);
        idle(1, 0);

        $display("[TB] full queue with continuous pipeline traffic");
        for (int i = 0; i < 4; i++) applyStimulus(1, 20, 32'h200 + i, 1, 5'(12 + i), 32'hC0 + i, 13, 15);
        checkOutput("full_q_count", {29'b0, q_count}, 4);
        checkOutput("full_ready", {31'b0, mdu_ready}, 0);
        applyStimulus(1, 20, 32'h2FF, 1, 16, 32'hC5, 16, 0);
        checkOutput("full_hold_q_count", {29'b0, q_count}, 4);
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) applyStimulus(0, 0, 0, 1, 16, 32'hC5, 16, 12);
        idle(6, 16);
        @(negedge clk); #1;
        checkOutput("full_rf15", rf[15], 32'hC3);
        checkOutput("full_rf16", rf[16], 32'hC5);

        $display("[TB] write-after-write kill");
        applyStimulus(1, 1, 32'h31, 1, 3, 32'h1, 3, 0);
        checkOutput("waw_hz_set", {31'b0, hazard_a}, 1);
        applyStimulus(1, 3, 32'h2, 0, 0, 0, 3, 0);
        checkOutput("waw_hz_clear", {31'b0, hazard_a}, 0);
        idle(1, 3);
        checkOutput("waw_pop_we", {31'b0, we}, 0);
        checkOutput("waw_q_count", {29'b0, q_count}, 0);
        @(negedge clk); #1;
        checkOutput("waw_rf3", rf[3], 32'h2);

        $display("[TB] simultaneous writes and r0");
        applyStimulus(1, 4, 32'hAAAA, 1, 4, 32'hBBBB, 4, 0);
        idle(1, 4);
        checkOutput("sim_pop_we", {31'b0, we}, 0);
        @(negedge clk); #1;
        checkOutput("sim_rf4", rf[4], 32'hAAAA);
        applyStimulus(0, 0, 0, 1, 0, 32'h5555, 0, 0);
        checkOutput("r0_q_count", {29'b0, q_count}, 0);
        checkOutput("r0_we", {31'b0, we}, 0);
        idle(1, 0);
        checkOutput("r0_we_next", {31'b0, we}, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 3) == 0, 5'($urandom_range(0, 7)), $urandom,
                          ($urandom % 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2, 0);
        @(negedge clk); #1;
        for (int i = 1; i < 8; i++) checkOutput($sformatf("rf_r%0d", i), rf[i], modelRf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
